// File: rtl/key_event_fifo.sv
// Key-event queue: latches debounced key pulses, priority-encodes them and queues key codes (FWFT).
// Define KEY_EVENT_TIMESTAMP_EN to store a free-running cycle timestamp with each entry (evt_ts port).
module key_event_fifo #(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_W     = 16,
  localparam int unsigned CODE_W  = $clog2(NUM_KEYS),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_pulse,
  output logic                evt_valid,
  output logic [CODE_W-1:0]   evt_code,
  input  logic                evt_ready,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                overflow,
  input  logic                clr_overflow
`ifdef KEY_EVENT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]     evt_ts
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (NUM_KEYS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
    $error("key_event_fifo: illegal parameter set");
  end

  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]   mem_q [DEPTH];
  logic [CODE_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;

  logic [CODE_W-1:0]   grant_idx_c;
  logic [NUM_KEYS-1:0] grant_c;
  logic [NUM_KEYS-1:0] taken_c;
  logic                push_c;
  logic                pop_c;

  // Lowest-index pending key wins the single push slot.
  always_comb begin
    grant_idx_c = '0;
    grant_c     = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_idx_c = CODE_W'(i);
        grant_c     = NUM_KEYS'(1) << i;
      end
    end
  end

  always_comb begin
    pop_c      = valid_q && evt_ready;
    push_c     = (pending_q != '0) && ((count_q != CNT_W'(DEPTH)) || pop_c);
    taken_c    = push_c ? grant_c : '0;
    pending_d  = (pending_q & ~taken_c) | key_pulse;
    // A pulse landing on a still-pending, not-taken key is absorbed; flag it.
    overflow_d = (|(key_pulse & pending_q & ~taken_c)) || (overflow_q && !clr_overflow);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    valid_d    = (count_d != '0);
    mem_d      = mem_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = grant_idx_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_code   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef KEY_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] ts_mem_q [DEPTH];
  logic [TS_W-1:0] ts_mem_d [DEPTH];

  // Free-running cycle stamp captured alongside each written code.
  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
    ts_mem_d = ts_mem_q;
    if (push_c) begin
      ts_mem_d[wr_ptr_q] = ts_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_mem_q <= '{default: '0};
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_mem_q <= ts_mem_d;
    end
  end

  assign evt_ts = ts_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo: vector table plus hand sequences, codes checked via a queue.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_pulse = '0;
  logic       evt_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [3:0] fifo_count;
  logic       overflow;
`ifdef KEY_EVENT_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  key_event_fifo #(.NUM_KEYS(4), .DEPTH(8), .TS_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_pulse    (key_pulse),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef KEY_EVENT_TIMESTAMP_EN
    ,
    .evt_ts       (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  typedef struct {
    logic [3:0] mask;
    int         exp_cnt;
    int         exp_head;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    key_pulse = m;
    tick();
    key_pulse = '0;
  endtask

  task automatic push_exp(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) exp_q.push_back(i);
    end
  endtask

  task automatic drain(input string name);
    evt_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (!evt_valid) break;
      if (exp_q.size() == 0) chk({name, " extra entry"}, 1, 0);
      else chk({name, " code"}, int'(evt_code), exp_q.pop_front());
      tick();
    end
    evt_ready = 1'b0;
    chk({name, " missing entries"}, exp_q.size(), 0);
    chk({name, " count after drain"}, int'(fifo_count), 0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{mask: 4'b1011, exp_cnt: 3, exp_head: 0};
    vecs[1] = '{mask: 4'b0001, exp_cnt: 1, exp_head: 0};
    vecs[2] = '{mask: 4'b1000, exp_cnt: 1, exp_head: 3};
    vecs[3] = '{mask: 4'b1111, exp_cnt: 4, exp_head: 0};
    vecs[4] = '{mask: 4'b0110, exp_cnt: 2, exp_head: 1};

    // Reset state, idle, and pops on an empty queue
    #1;
    chk("rst valid", int'(evt_valid), 0);
    chk("rst count", int'(fifo_count), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst code", int'(evt_code), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle valid", int'(evt_valid), 0);
    chk("idle count", int'(fifo_count), 0);
    chk("idle overflow", int'(overflow), 0);
    evt_ready = 1'b1;
    repeat (3) tick();
    evt_ready = 1'b0;
    chk("empty pop count", int'(fifo_count), 0);
    chk("empty pop valid", int'(evt_valid), 0);

    // Single press latency: visible two edges after the pulse is sampled
    pulse(4'b0100);
    chk("single valid after 1 edge", int'(evt_valid), 0);
    tick();
    chk("single valid after 2 edges", int'(evt_valid), 1);
    chk("single code", int'(evt_code), 2);
    chk("single count", int'(fifo_count), 1);
    push_exp(4'b0100);
    drain("single");

    // Simultaneous-press vector table
    foreach (vecs[v]) begin
      pulse(vecs[v].mask);
      push_exp(vecs[v].mask);
      repeat (5) tick();
      chk($sformatf("vec%0d count", v), int'(fifo_count), vecs[v].exp_cnt);
      chk($sformatf("vec%0d head", v), int'(evt_code), vecs[v].exp_head);
      chk($sformatf("vec%0d overflow", v), int'(overflow), 0);
      drain($sformatf("vec%0d", v));
    end

    // Re-pulse of the key granted in that same cycle is a new event
    pulse(4'b0001);
    pulse(4'b0001);
    tick(); tick();
    chk("regrant overflow", int'(overflow), 0);
    chk("regrant count", int'(fifo_count), 2);
    push_exp(4'b0001); push_exp(4'b0001);
    drain("regrant");

    // Merge on a pending key sets overflow even with clr_overflow asserted
    pulse(4'b0011);
    key_pulse = 4'b0010;
    clr_overflow = 1'b1;
    tick();
    key_pulse = '0;
    clr_overflow = 1'b0;
    chk("merge overflow set wins", int'(overflow), 1);
    tick(); tick();
    chk("merge count", int'(fifo_count), 2);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("merge clr", int'(overflow), 0);
    push_exp(4'b0011);
    drain("merge");

    // Fill to DEPTH, then blocked and merged presses
    for (int k = 0; k < 8; k++) begin
      pulse(4'b0010);
      tick(); tick();
      push_exp(4'b0010);
    end
    chk("fill count", int'(fifo_count), 8);
    chk("fill valid", int'(evt_valid), 1);
    pulse(4'b0010);
    push_exp(4'b0010);
    tick(); tick();
    chk("full blocked count", int'(fifo_count), 8);
    chk("full blocked overflow", int'(overflow), 0);
    pulse(4'b0010);
    chk("full merge overflow", int'(overflow), 1);
    evt_ready = 1'b1;
    chk("full pop code", int'(evt_code), exp_q.pop_front());
    tick();
    evt_ready = 1'b0;
    chk("full pop+pending count", int'(fifo_count), 8);
    tick();
    chk("full settle count", int'(fifo_count), 8);

    // Push and pop in the same cycle at full
    pulse(4'b1000);
    tick();
    chk("full hold count", int'(fifo_count), 8);
    evt_ready = 1'b1;
    chk("full swap code", int'(evt_code), exp_q.pop_front());
    tick();
    evt_ready = 1'b0;
    push_exp(4'b1000);
    chk("full swap count", int'(fifo_count), 8);
    chk("full overflow sticky", int'(overflow), 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("full clr overflow", int'(overflow), 0);
    drain("full");

    // Push/pop traffic across pointer wrap
    for (int it = 0; it < 20; it++) begin
      int k;
      logic [3:0] m;
      k = int'($urandom_range(0, 3));
      m = 4'(1 << k);
      pulse(m);
      push_exp(m);
      tick();
      chk($sformatf("wrap%0d valid", it), int'(evt_valid), 1);
      chk($sformatf("wrap%0d code", it), int'(evt_code), exp_q.pop_front());
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk($sformatf("wrap%0d count", it), int'(fifo_count), 0);
    end

    // Asynchronous reset mid-burst
    key_pulse = 4'b1111;
    tick();
    key_pulse = '0;
    tick(); tick();
    chk("burst count", int'(fifo_count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count", int'(fifo_count), 0);
    chk("async rst valid", int'(evt_valid), 0);
    tick();
    chk("rst held count", int'(fifo_count), 0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post rst pending cleared", int'(fifo_count), 0);
    chk("post rst valid", int'(evt_valid), 0);
    exp_q.delete();

`ifdef KEY_EVENT_TIMESTAMP_EN
    // Timestamps of entries written 3 cycles apart differ by 3
    begin
      logic [15:0] ts[3];
      pulse(4'b0001); tick(); tick();
      pulse(4'b0100); tick(); tick();
      pulse(4'b0010); tick(); tick();
      chk("ts count", int'(fifo_count), 3);
      evt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        ts[i] = evt_ts;
        tick();
      end
      evt_ready = 1'b0;
      chk("ts delta 0-1", int'(16'(ts[1] - ts[0])), 3);
      chk("ts delta 1-2", int'(16'(ts[2] - ts[1])), 3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
